// File: rtl/sd_spi_master.sv
// SPI master (mode 0, MSB first, 8-bit frames) for the SD card slot.
// Bus accesses are level-held selects answered by exactly one bus_ack pulse;
// a DATA write holds off its ack until the whole byte has been shifted.
module sd_spi_master #(
  parameter int DEFAULT_DIV = 49,
  parameter int DIV_W       = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cs,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss_n
);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic               samp_q, samp_d;
  logic [7:0]         rx_q, rx_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               ssn_q, ssn_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               armed_q, armed_d;
  logic               start;
  logic               half_end;

  // Address bits outside [3:2] and upper write-data bits are not decoded.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus_addr[31:4], bus_addr[1:0], bus_wdata[31:8]};

  assign start    = cs & (bus_wr | bus_rd) & (state_q == IDLE) & armed_q;
  assign half_end = (cnt_q == div_q);

  // Next-state: bus decode in IDLE, SCLK half-period timing while shifting.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    samp_d  = samp_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ssn_d   = ssn_q;
    ack_d   = 1'b0;
    rdata_d = 32'h0;
    armed_d = armed_q;
    // Re-arm only once the master has released the select.
    if (!cs) armed_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          armed_d = 1'b0;
          if (bus_wr) begin
            case (bus_addr[3:2])
              2'd0: begin
                sh_d    = bus_wdata[7:0];
                mosi_d  = bus_wdata[7];
                cnt_d   = '0;
                bit_d   = 3'd0;
                state_d = SHIFT_LO;
              end
              2'd1: begin ssn_d = bus_wdata[0];       ack_d = 1'b1; end
              2'd2: begin div_d = bus_wdata[DIV_W-1:0]; ack_d = 1'b1; end
              default: ack_d = 1'b1;
            endcase
          end else begin
            ack_d = 1'b1;
            case (bus_addr[3:2])
              2'd0:    rdata_d = {24'h0, rx_q};
              2'd1:    rdata_d = {31'h0, ssn_q};
              2'd2:    rdata_d = {{(32-DIV_W){1'b0}}, div_q};
              default: rdata_d = 32'h0;
            endcase
          end
        end
      end
      SHIFT_LO: begin
        if (half_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          samp_d  = miso;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (half_end) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          // The sample is held aside until the falling edge so the tx LSB
          // is not overwritten before it has been shifted out.
          if (bit_q != 3'd7) begin
            sh_d    = {sh_q[6:0], samp_q};
            mosi_d  = sh_q[6];
            bit_d   = bit_q + 3'd1;
            state_d = SHIFT_LO;
          end else begin
            rx_d    = {sh_q[6:0], samp_q};
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        mosi_d  = 1'b1;
        ack_d   = cs;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      div_q   <= DIV_W'(DEFAULT_DIV);
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h0;
      samp_q  <= 1'b0;
      rx_q    <= 8'h0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      ssn_q   <= 1'b1;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      samp_q  <= samp_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ssn_q   <= ssn_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      armed_q <= armed_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign ss_n      = ssn_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: register table, SPI transfers against a slave
// model, single-ack guarantee, cs drop mid-frame and reset mid-frame.
module tb_sd_spi_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cs, bus_wr, bus_rd;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, sclk, mosi, miso, ss_n;

  sd_spi_master dut (
    .clk(clk), .resetn(resetn), .cs(cs), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // SPI slave model: shifts slv out MSB first, captures mosi on rising sclk.
  logic [7:0] slv = 8'h00;
  logic [7:0] cap = 8'h00;
  int         nrise = 0;
  int         nbase = 0;
  logic [2:0] idx;
  assign idx  = 3'(nrise - nbase);
  assign miso = slv[~idx];
  always @(posedge sclk) begin
    cap   <= {cap[6:0], mosi};
    nrise <= nrise + 1;
  end

  int ack_cnt = 0;
  always @(posedge clk) if (bus_ack) ack_cnt <= ack_cnt + 1;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One bus access; expectation queued at drive time, compared at ack.
  task automatic access(input logic wr, input logic rd, input logic [3:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input int exp_lat, input string name);
    exp_t e;
    int   lat;
    logic got;
    e.chk_rd = rd & ~wr; e.rdata = exp_rd; e.lat = exp_lat; e.name = name;
    sb.push_back(e);
    cs = 1'b1; bus_wr = wr; bus_rd = rd;
    bus_addr = {28'h4000000, a}; bus_wdata = wd;
    lat = 0; got = 1'b0;
    while (!got && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if (bus_ack) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_ack required=ack", e.name);
    end else begin
      if (e.chk_rd)  chk({e.name, "_rdata"}, bus_rdata, e.rdata);
      if (e.lat > 0) chk({e.name, "_lat"}, 32'(lat), 32'(e.lat));
    end
    cs = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        wr, rd;
    logic [3:0]  a;
    logic [31:0] wd, exp_rd;
    logic        exp_ssn;
    string       name;
  } vec_t;
  vec_t vt[12];

  int a0, n;

  initial begin
    vt[0]  = '{1'b0, 1'b1, 4'h8, 32'h0,        32'd49,  1'b1, "rd_div_reset"};
    vt[1]  = '{1'b1, 1'b0, 4'h4, 32'h0,        32'h0,   1'b0, "wr_ctrl0"};
    vt[2]  = '{1'b0, 1'b1, 4'h4, 32'h0,        32'h0,   1'b0, "rd_ctrl0"};
    vt[3]  = '{1'b1, 1'b0, 4'h4, 32'hFFFFFFFF, 32'h0,   1'b1, "wr_ctrl_all"};
    vt[4]  = '{1'b0, 1'b1, 4'h4, 32'h0,        32'h1,   1'b1, "rd_ctrl1"};
    vt[5]  = '{1'b1, 1'b0, 4'h8, 32'h000001A5, 32'h0,   1'b1, "wr_div"};
    vt[6]  = '{1'b0, 1'b1, 4'h8, 32'h0,        32'hA5,  1'b1, "rd_div"};
    vt[7]  = '{1'b1, 1'b0, 4'hC, 32'hDEADBEEF, 32'h0,   1'b1, "wr_rsvd"};
    vt[8]  = '{1'b0, 1'b1, 4'hC, 32'h0,        32'h0,   1'b1, "rd_rsvd"};
    vt[9]  = '{1'b1, 1'b1, 4'h4, 32'h0,        32'h0,   1'b0, "wrrd_ctrl"};
    vt[10] = '{1'b1, 1'b0, 4'h4, 32'h1,        32'h0,   1'b1, "wr_ctrl1"};
    vt[11] = '{1'b1, 1'b0, 4'h8, 32'h1,        32'h0,   1'b1, "wr_div1"};

    // T1 reset
    resetn = 1'b0; cs = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0;
    bus_addr = 32'h0; bus_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd1);
    chk("rst_ssn",  32'(ss_n), 32'd1);
    chk("rst_ack",  32'(bus_ack), 32'd0);
    chk("rst_rdata", bus_rdata, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // T2 register table (ends with DIV=1)
    for (int i = 0; i < 12; i++) begin
      access(vt[i].wr, vt[i].rd, vt[i].a, vt[i].wd, vt[i].exp_rd, 1, vt[i].name);
      chk({vt[i].name, "_ssn"}, 32'(ss_n), 32'(vt[i].exp_ssn));
    end

    // T3 transfer at DIV=1
    nbase = nrise; slv = 8'h3C;
    access(1'b1, 1'b0, 4'h0, 32'h000000A5, 32'h0, 34, "xfer_a5");
    chk("xfer_a5_mosi", 32'(cap), 32'hA5);
    chk("xfer_a5_edges", 32'(nrise - nbase), 32'd8);
    chk("xfer_a5_mosi_idle", 32'(mosi), 32'd1);
    access(1'b0, 1'b1, 4'h0, 32'h0, 32'h3C, 1, "rd_data_3c");

    // DIV=0 boundary
    access(1'b1, 1'b0, 4'h8, 32'h0, 32'h0, 1, "wr_div0");
    nbase = nrise; slv = 8'h81;
    access(1'b1, 1'b0, 4'h0, 32'h7E, 32'h0, 18, "xfer_div0");
    chk("xfer_div0_mosi", 32'(cap), 32'h7E);
    access(1'b0, 1'b1, 4'h0, 32'h0, 32'h81, 1, "rd_data_81");

    // T4 cs held after ack: one ack only, then re-armed by cs low
    cs = 1'b1; bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = 32'h40000004;
    a0 = ack_cnt;
    repeat (7) @(posedge clk);
    #1;
    chk("held_cs_acks", 32'(ack_cnt - a0), 32'd1);
    cs = 1'b0; bus_rd = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 4'h4, 32'h0, 32'h1, 1, "rearm_rd_ctrl");

    // T5 cs dropped at cycle 10 of a DIV=3 transfer
    access(1'b1, 1'b0, 4'h8, 32'h3, 32'h0, 1, "wr_div3");
    nbase = nrise; slv = 8'h96;
    cs = 1'b1; bus_wr = 1'b1; bus_addr = 32'h40000000; bus_wdata = 32'h5A;
    repeat (10) @(posedge clk);
    #1;
    cs = 1'b0; bus_wr = 1'b0;
    a0 = ack_cnt;
    repeat (80) @(posedge clk);
    #1;
    chk("csdrop_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("csdrop_edges", 32'(nrise - nbase), 32'd8);
    chk("csdrop_mosi", 32'(cap), 32'h5A);
    access(1'b0, 1'b1, 4'h0, 32'h0, 32'h96, 1, "csdrop_rd_data");

    // T6 reset during bit 4
    access(1'b1, 1'b0, 4'h8, 32'h1, 32'h0, 1, "wr_div1b");
    access(1'b1, 1'b0, 4'h4, 32'h0, 32'h0, 1, "wr_ctrl0b");
    nbase = nrise; slv = 8'h00;
    cs = 1'b1; bus_wr = 1'b1; bus_addr = 32'h40000000; bus_wdata = 32'h33;
    n = 0;
    while ((nrise - nbase) < 4 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("midrst_reached_bit4", 32'(nrise - nbase), 32'd4);
    resetn = 1'b0; cs = 1'b0; bus_wr = 1'b0;
    @(posedge clk); #1;
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_mosi", 32'(mosi), 32'd1);
    chk("midrst_ssn",  32'(ss_n), 32'd1);
    chk("midrst_ack",  32'(bus_ack), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 1'b1, 4'h8, 32'h0, 32'd49, 1, "midrst_rd_div");
    access(1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1, "midrst_rd_data");
    nbase = nrise; slv = 8'hC3;
    access(1'b1, 1'b0, 4'h0, 32'hFF, 32'h0, 16*50+2, "post_rst_xfer");
    chk("post_rst_mosi", 32'(cap), 32'hFF);
    chk("post_rst_edges", 32'(nrise - nbase), 32'd8);
    access(1'b0, 1'b1, 4'h0, 32'h0, 32'hC3, 1, "post_rst_rd_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
